stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
Parametrised N-channel streaming multiplexer with valid/ready handshakes on every input and on the output. It selects one input per cycle, either by an explicit select (fixed mode) or by fair round-robin arbitration (RR mode). The winning input is captured into a registered output stage, so the output is timing-clean. It is the drop-in sequential replacement for the team's combinational 4:1 select muxes on datapaths that need back-pressure.

Parameters:
NUM_CH, 4, number of input channels (at least 2)
WIDTH, 8, data width per channel in bits
SEL_W, $clog2(NUM_CH), width of the select and channel-ID fields (derived; do not override)

Ports:
Clk  input  1  rising-edge clock
Rst  input  1  asynchronous, active-high reset
In_Data  input  NUM_CH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH]
In_Valid  input  NUM_CH  per-channel valid
In_Ready  output  NUM_CH  per-channel ready
Mode  input  1  0 = fixed select by Sel; 1 = round-robin
Sel  input  SEL_W  channel index used when Mode=0
Out_Data  output  WIDTH  registered selected data
Out_Valid  output  1  registered output valid
Out_Ready  input  1  downstream ready
Out_Ch  output  SEL_W  index of the channel that sourced Out_Data

Behaviour:
- Clock and reset: one clock, Clk. Reset Rst is asynchronous and active-high.
- Reset values: Out_Valid=0, Out_Data=0, Out_Ch=0, RR pointer last=NUM_CH-1 (so channel 0 has first priority after reset).
- load_en = !Out_Valid || Out_Ready. The output stage accepts new data when it is empty or being drained in the same cycle. This gives full throughput of 1 transfer/cycle.
- Grant is combinational and one-hot (or zero) over channels:
  - Mode=0: grant[Sel] = In_Valid[Sel]. If Sel >= NUM_CH (non-power-of-2 NUM_CH), there is no grant.
  - Mode=1: the first channel with In_Valid=1, searching from last+1 upward with wrap-around modulo NUM_CH. There is no grant if all In_Valid=0.
- In_Ready[i] = load_en && grant[i]. At most one In_Ready is high per cycle. In_Ready never depends on In_Valid of other channels while Mode=0.
- Transfer on channel i happens when In_Valid[i] && In_Ready[i]. On the next edge:
  - Out_Data <= channel i data.
  - Out_Ch <= i.
  - Out_Valid <= 1.
  - In RR mode, last <= i.
- If load_en=1 and there is no grant, Out_Valid <= 0 on the next edge. Out_Data and Out_Ch hold their old values.
- Stall: while Out_Valid && !Out_Ready, Out_Data, Out_Ch and Out_Valid are held stable and all In_Ready=0.
- Latency: 1 cycle from input transfer to Out_Valid.
- The RR pointer updates only on an accepted transfer, never on a stall. In Mode=0 the pointer is frozen.
- A Mode or Sel change takes effect on the same-cycle grant. It never alters data already held in the output register.
- Inputs are not required to hold In_Valid without a handshake. The mux tolerates a valid being withdrawn, but standard valid/ready rules are still expected upstream.
- Reset asserted mid-transfer clears Out_Valid immediately (asynchronous). Any in-flight word is dropped and the RR pointer returns to NUM_CH-1.

Decomposition:
- Shared package holds the mode constants MODE_FIXED=1'b0 and MODE_RR=1'b1, and a clog2-safe SEL_W helper.
- One sub-module, rr_arbiter (NUM_CH):
  - Inputs: req, an enable, Clk, Rst.
  - Outputs: one-hot grant and the encoded grant index.
  - It owns the last pointer, which updates when enable && |grant.
- The top level does mode selection, In_Ready gating and the output register.

Test Plan:
- Reset: assert Rst mid-stream with Out_Valid=1 -> Out_Valid=0, Out_Data=0 and Out_Ch=0 immediately; first RR grant after release goes to channel 0 when all are valid.
- Fixed mode: Mode=0, Sel=2, In_Valid=4'b1111, ch2 data=8'hA5, Out_Ready=1 -> next cycle Out_Data=8'hA5, Out_Ch=2; In_Ready=4'b0100 every cycle.
- Round-robin fairness: Mode=1, all four valid continuously, Out_Ready=1 -> Out_Ch sequence 0,1,2,3,0,... with one transfer per cycle.
- RR skip and wrap: last=1, In_Valid=4'b1001 -> grant ch3, then ch0, then ch3 again.
- Back-pressure: Out_Ready=0 for 3 cycles with Out_Valid=1 -> Out_Data and Out_Ch stable, In_Ready=0; the RR pointer does not advance; transfer resumes the cycle Out_Ready=1.
- No requester: In_Valid=0, Out_Ready=1 -> Out_Valid falls to 0 after one cycle; Mode=0 with Sel=5 (NUM_CH=5 build, Sel width 3, set Sel=3'd5) -> no grant.

Source files
------------

// File: rtl/stream_mux_rr_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer.
package stream_mux_rr_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Keeps index fields at least one bit wide even for degenerate channel counts.
    function automatic int sel_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin arbiter: searches from the channel after the last winner, with wrap-around.
module rr_arbiter
    import stream_mux_rr_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = sel_w(NUM_CH)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [NUM_CH-1:0] Req,
    input  logic              En,
    output logic [NUM_CH-1:0] Grant,
    output logic [SEL_W-1:0]  Grant_Idx
);

    localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(NUM_CH - 1);

    logic [SEL_W-1:0] r_last;
    logic [SEL_W-1:0] w_cand;
    logic             w_found;

    always_comb begin
        Grant     = '0;
        Grant_Idx = '0;
        w_cand    = '0;
        w_found   = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_cand = SEL_W'((int'(r_last) + k) % NUM_CH);
            if (!w_found && Req[w_cand]) begin
                w_found         = 1'b1;
                Grant[w_cand]   = 1'b1;
                Grant_Idx       = w_cand;
            end
        end
    end

    // Pointer moves only when the grant is actually accepted.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_last <= LAST_RST;
        end else if (En && (|Grant)) begin
            r_last <= Grant_Idx;
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with fixed or round-robin selection and a registered output stage.
module stream_mux_rr
    import stream_mux_rr_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8,
    parameter int SEL_W  = sel_w(NUM_CH)
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [NUM_CH*WIDTH-1:0] In_Data,
    input  logic [NUM_CH-1:0]       In_Valid,
    output logic [NUM_CH-1:0]       In_Ready,
    input  logic                    Mode,
    input  logic [SEL_W-1:0]        Sel,
    output logic [WIDTH-1:0]        Out_Data,
    output logic                    Out_Valid,
    input  logic                    Out_Ready,
    output logic [SEL_W-1:0]        Out_Ch
);

    logic              w_load_en;
    logic              w_rr_en;
    logic [NUM_CH-1:0] w_fix_grant;
    logic [NUM_CH-1:0] w_rr_grant;
    logic [NUM_CH-1:0] w_grant;
    logic [SEL_W-1:0]  w_rr_idx;
    logic [SEL_W-1:0]  w_idx;
    logic [WIDTH-1:0]  w_data;

    logic              r_out_valid;
    logic [WIDTH-1:0]  r_out_data;
    logic [SEL_W-1:0]  r_out_ch;

    assign w_load_en = !r_out_valid || Out_Ready;
    assign w_rr_en   = w_load_en && (Mode == MODE_RR);

    // Compare against every legal index so an out-of-range Sel simply matches nothing.
    always_comb begin
        w_fix_grant = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (Sel == SEL_W'(i)) begin
                w_fix_grant[i] = In_Valid[i];
            end
        end
    end

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_arb (
        .Clk       (Clk),
        .Rst       (Rst),
        .Req       (In_Valid),
        .En        (w_rr_en),
        .Grant     (w_rr_grant),
        .Grant_Idx (w_rr_idx)
    );

    assign w_grant  = (Mode == MODE_RR) ? w_rr_grant : w_fix_grant;
    assign w_idx    = (Mode == MODE_RR) ? w_rr_idx : Sel;
    assign In_Ready = w_load_en ? w_grant : '0;

    always_comb begin
        w_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_grant[i]) begin
                w_data = In_Data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
        end else if (w_load_en) begin
            if (|w_grant) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_data;
                r_out_ch    <= w_idx;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign Out_Valid = r_out_valid;
    assign Out_Data  = r_out_data;
    assign Out_Ch    = r_out_ch;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: vector table with a transfer scoreboard, plus reset and 5-channel corner sequences.
module tb_stream_mux_rr;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Rst;
    logic [31:0] In_Data;
    logic [3:0]  In_Valid;
    logic [3:0]  In_Ready;
    logic        Mode;
    logic [1:0]  Sel;
    logic [7:0]  Out_Data;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [1:0]  Out_Ch;

    logic [39:0] In_Data_5;
    logic [4:0]  In_Valid_5;
    logic [4:0]  In_Ready_5;
    logic        Mode_5;
    logic [2:0]  Sel_5;
    logic [7:0]  Out_Data_5;
    logic        Out_Valid_5;
    logic        Out_Ready_5;
    logic [2:0]  Out_Ch_5;

    stream_mux_rr #(.NUM_CH(4), .WIDTH(8)) dut (
        .Clk(Clk), .Rst(Rst), .In_Data(In_Data), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .Mode(Mode), .Sel(Sel), .Out_Data(Out_Data), .Out_Valid(Out_Valid),
        .Out_Ready(Out_Ready), .Out_Ch(Out_Ch)
    );

    stream_mux_rr #(.NUM_CH(5), .WIDTH(8)) dut5 (
        .Clk(Clk), .Rst(Rst), .In_Data(In_Data_5), .In_Valid(In_Valid_5), .In_Ready(In_Ready_5),
        .Mode(Mode_5), .Sel(Sel_5), .Out_Data(Out_Data_5), .Out_Valid(Out_Valid_5),
        .Out_Ready(Out_Ready_5), .Out_Ch(Out_Ch_5)
    );

    typedef struct {
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  valid;
        logic        ordy;
        logic [31:0] data;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [1:0]  exp_ch;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [1:0] ch;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[20];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] data, input logic [3:0] rdy);
        exp_t e;
        e.data = 8'h00;
        e.ch   = 2'd0;
        for (int j = 0; j < 4; j++) begin
            if (rdy[j]) begin
                e.data = data[j*8 +: 8];
                e.ch   = 2'(j);
            end
        end
        sb_q.push_back(e);
    endtask

    // Every drained output word must match the oldest expected transfer.
    always @(negedge Clk) begin
        if (!Rst && Out_Valid && Out_Ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected actual ch=%0d data=%02h required=no output", Out_Ch, Out_Data);
            end else begin
                mon_e = sb_q.pop_front();
                if (Out_Data !== mon_e.data || Out_Ch !== mon_e.ch) begin
                    failures++;
                    $display("FAIL sb_word actual ch=%0d data=%02h required ch=%0d data=%02h",
                             Out_Ch, Out_Data, mon_e.ch, mon_e.data);
                end
            end
        end
    end

    initial begin
        //           mode  sel   valid    ordy  data          exp_rdy  ov    ch
        vecs[0]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 32'h44A52211, 4'b0100, 1'b1, 2'd2};
        vecs[1]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 32'h55B63322, 4'b0100, 1'b1, 2'd2};
        vecs[2]  = '{1'b0, 2'd1, 4'b1101, 1'b1, 32'h66C74433, 4'b0000, 1'b0, 2'd2};
        vecs[3]  = '{1'b0, 2'd0, 4'b0001, 1'b1, 32'h77D85544, 4'b0001, 1'b1, 2'd0};
        vecs[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 32'h01020304, 4'b0001, 1'b1, 2'd0};
        vecs[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 32'h11121314, 4'b0010, 1'b1, 2'd1};
        vecs[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 32'h21222324, 4'b0100, 1'b1, 2'd2};
        vecs[7]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 32'h31323334, 4'b1000, 1'b1, 2'd3};
        vecs[8]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 32'h41424344, 4'b0001, 1'b1, 2'd0};
        vecs[9]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 32'h51525354, 4'b0010, 1'b1, 2'd1};
        vecs[10] = '{1'b1, 2'd0, 4'b1001, 1'b1, 32'h61626364, 4'b1000, 1'b1, 2'd3};
        vecs[11] = '{1'b1, 2'd0, 4'b1001, 1'b1, 32'h71727374, 4'b0001, 1'b1, 2'd0};
        vecs[12] = '{1'b1, 2'd0, 4'b1001, 1'b1, 32'h81828384, 4'b1000, 1'b1, 2'd3};
        vecs[13] = '{1'b1, 2'd0, 4'b1111, 1'b0, 32'h91929394, 4'b0000, 1'b1, 2'd3};
        vecs[14] = '{1'b1, 2'd0, 4'b1111, 1'b0, 32'hA1A2A3A4, 4'b0000, 1'b1, 2'd3};
        vecs[15] = '{1'b1, 2'd0, 4'b1111, 1'b0, 32'hB1B2B3B4, 4'b0000, 1'b1, 2'd3};
        vecs[16] = '{1'b1, 2'd0, 4'b1111, 1'b1, 32'hC1C2C3C4, 4'b0001, 1'b1, 2'd0};
        vecs[17] = '{1'b1, 2'd0, 4'b1111, 1'b1, 32'hD1D2D3D4, 4'b0010, 1'b1, 2'd1};
        vecs[18] = '{1'b1, 2'd0, 4'b0000, 1'b1, 32'hE1E2E3E4, 4'b0000, 1'b0, 2'd1};
        vecs[19] = '{1'b1, 2'd0, 4'b0000, 1'b1, 32'hF1F2F3F4, 4'b0000, 1'b0, 2'd1};

        Rst         = 1'b1;
        In_Data     = '0;
        In_Valid    = '0;
        Mode        = 1'b0;
        Sel         = '0;
        Out_Ready   = 1'b0;
        In_Data_5   = '0;
        In_Valid_5  = '0;
        Mode_5      = 1'b0;
        Sel_5       = '0;
        Out_Ready_5 = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;
        chk("rst_out_valid", 32'(Out_Valid), 32'd0);
        chk("rst_out_data", 32'(Out_Data), 32'd0);
        chk("rst_out_ch", 32'(Out_Ch), 32'd0);
        chk("rst_in_ready", 32'(In_Ready), 32'd0);

        for (int i = 0; i < 20; i++) begin
            Mode      = vecs[i].mode;
            Sel       = vecs[i].sel;
            In_Valid  = vecs[i].valid;
            Out_Ready = vecs[i].ordy;
            In_Data   = vecs[i].data;
            @(negedge Clk);
            chk($sformatf("v%0d_in_ready", i), 32'(In_Ready), 32'(vecs[i].exp_rdy));
            if (vecs[i].exp_rdy != 4'b0000) push_exp(vecs[i].data, vecs[i].exp_rdy);
            @(posedge Clk);
            #1;
            chk($sformatf("v%0d_out_valid", i), 32'(Out_Valid), 32'(vecs[i].exp_ov));
            chk($sformatf("v%0d_out_ch", i), 32'(Out_Ch), 32'(vecs[i].exp_ch));
        end

        // Reset mid-stream: load a word, stall it, then assert reset between edges.
        Mode      = 1'b1;
        In_Valid  = 4'b1111;
        Out_Ready = 1'b1;
        In_Data   = 32'h13579BDF;
        @(negedge Clk);
        chk("pre_rst_in_ready", 32'(In_Ready), 32'b0100);
        @(posedge Clk);
        #1;
        Out_Ready = 1'b0;
        chk("pre_rst_out_valid", 32'(Out_Valid), 32'd1);
        chk("pre_rst_out_ch", 32'(Out_Ch), 32'd2);
        @(negedge Clk);
        #2;
        Rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(Out_Valid), 32'd0);
        chk("async_rst_out_data", 32'(Out_Data), 32'd0);
        chk("async_rst_out_ch", 32'(Out_Ch), 32'd0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        sb_q.delete();
        Out_Ready = 1'b1;
        In_Data   = 32'h2468ACE0;
        @(negedge Clk);
        chk("post_rst_in_ready", 32'(In_Ready), 32'b0001);
        push_exp(In_Data, 4'b0001);
        @(posedge Clk);
        #1;
        chk("post_rst_out_ch", 32'(Out_Ch), 32'd0);
        In_Valid = 4'b0000;
        repeat (2) @(posedge Clk);
        #1;
        chk("post_rst_drained", 32'(Out_Valid), 32'd0);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        // Five-channel build: Sel=5 is out of range and must never grant.
        Mode_5      = 1'b0;
        Sel_5       = 3'd5;
        In_Valid_5  = 5'b11111;
        Out_Ready_5 = 1'b1;
        In_Data_5   = 40'h9A_78_56_34_12;
        @(negedge Clk);
        chk("n5_sel5_in_ready", 32'(In_Ready_5), 32'd0);
        @(posedge Clk);
        #1;
        chk("n5_sel5_out_valid", 32'(Out_Valid_5), 32'd0);
        Sel_5 = 3'd4;
        @(negedge Clk);
        chk("n5_sel4_in_ready", 32'(In_Ready_5), 32'b10000);
        @(posedge Clk);
        #1;
        chk("n5_sel4_out_valid", 32'(Out_Valid_5), 32'd1);
        chk("n5_sel4_out_ch", 32'(Out_Ch_5), 32'd4);
        chk("n5_sel4_out_data", 32'(Out_Data_5), 32'h9A);
        Mode_5 = 1'b1;
        @(negedge Clk);
        chk("n5_rr_first_in_ready", 32'(In_Ready_5), 32'b00001);
        @(posedge Clk);
        #1;
        chk("n5_rr_first_out_data", 32'(Out_Data_5), 32'h12);
        In_Valid_5 = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
